router_pkt_tx: RTL and testbench

- Packet transmitter that drives the 1x3 router input port (tx_data -> data_in, pkt_valid, busy back-pressure).
- Accepts a command (destination, length) plus a payload byte stream.
- Buffers the full payload, then emits header, payload and parity in router framing, honouring busy.
- Used as the on-chip upstream source and as the reusable stimulus engine for router benches.

---
 rtl/router_pkt_tx_if.sv | 30 +++
 rtl/router_pkt_tx.sv | 163 ++++++++++++++++
 tb/tb_router_pkt_tx.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// Bundles the command, payload-source and router-side signals of router_pkt_tx.
// slave is the transmitter's view; master is the view of whatever drives it.
interface router_pkt_tx_if #(
   parameter int unsigned CNT_W = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_addr;
   logic [5:0]       cmd_len;
   logic             cmd_inj_err;
   logic [7:0]       src_data;
   logic             src_valid;
   logic             src_ready;
   logic             busy;
   logic [7:0]       tx_data;
   logic             pkt_valid;
   logic             tx_done;
   logic             cmd_err;
   logic [CNT_W-1:0] pkt_count;

   modport slave (
      input  cmd_valid, cmd_addr, cmd_len, cmd_inj_err, src_data, src_valid, busy,
      output cmd_ready, src_ready, tx_data, pkt_valid, tx_done, cmd_err, pkt_count
   );

   modport master (
      output cmd_valid, cmd_addr, cmd_len, cmd_inj_err, src_data, src_valid, busy,
      input  cmd_ready, src_ready, tx_data, pkt_valid, tx_done, cmd_err, pkt_count
   );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 1x3 router input port: buffers a whole payload,
// then sends header, payload and parity while honouring router busy.
module router_pkt_tx #(
   parameter int unsigned IPG   = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic           clock,
   input  logic           reset,
   router_pkt_tx_if.slave bus
);
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned LEN_W  = 6;
   localparam int unsigned GAP_W  = 4;
   localparam int unsigned DEPTH  = 64;

   typedef enum logic [2:0] {IDLE, FILL, HEADER, PAYLOAD, PARITY, GAP} state_t;

   state_t              r_state,     w_state_nxt;
   logic [LEN_W-1:0]    r_len,       w_len_nxt;
   logic [BYTE_W-1:0]   r_hdr,       w_hdr_nxt;
   logic                r_inj,       w_inj_nxt;
   logic [LEN_W-1:0]    r_wptr,      w_wptr_nxt;
   logic [LEN_W-1:0]    r_rptr,      w_rptr_nxt;
   logic [BYTE_W-1:0]   r_parity,    w_parity_nxt;
   logic [GAP_W-1:0]    r_gap,       w_gap_nxt;
   logic [BYTE_W-1:0]   r_tx_data,   w_tx_data_nxt;
   logic                r_pkt_valid, w_pkt_valid_nxt;
   logic                r_tx_done,   w_tx_done_nxt;
   logic                r_cmd_err,   w_cmd_err_nxt;
   logic [CNT_W-1:0]    r_pkt_count, w_pkt_count_nxt;
   logic                w_buf_we;
   logic [LEN_W-1:0]    w_last_idx;
   logic [LEN_W-1:0]    w_rptr_inc;
   logic [BYTE_W-1:0]   r_buf [DEPTH];

   assign w_last_idx = r_len - LEN_W'(1);
   assign w_rptr_inc = r_rptr + LEN_W'(1);

   // Payload store; contents are only meaningful up to the latched length.
   always_ff @(posedge clock) begin
      if (w_buf_we) r_buf[r_wptr] <= bus.src_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_hdr       <= '0;
         r_inj       <= 1'b0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_parity    <= '0;
         r_gap       <= '0;
         r_tx_data   <= '0;
         r_pkt_valid <= 1'b0;
         r_tx_done   <= 1'b0;
         r_cmd_err   <= 1'b0;
         r_pkt_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_len       <= w_len_nxt;
         r_hdr       <= w_hdr_nxt;
         r_inj       <= w_inj_nxt;
         r_wptr      <= w_wptr_nxt;
         r_rptr      <= w_rptr_nxt;
         r_parity    <= w_parity_nxt;
         r_gap       <= w_gap_nxt;
         r_tx_data   <= w_tx_data_nxt;
         r_pkt_valid <= w_pkt_valid_nxt;
         r_tx_done   <= w_tx_done_nxt;
         r_cmd_err   <= w_cmd_err_nxt;
         r_pkt_count <= w_pkt_count_nxt;
      end
   end

   // Next state and next values of every registered output.
   always_comb begin
      w_state_nxt     = r_state;
      w_len_nxt       = r_len;
      w_hdr_nxt       = r_hdr;
      w_inj_nxt       = r_inj;
      w_wptr_nxt      = r_wptr;
      w_rptr_nxt      = r_rptr;
      w_parity_nxt    = r_parity;
      w_gap_nxt       = r_gap;
      w_tx_data_nxt   = r_tx_data;
      w_pkt_valid_nxt = r_pkt_valid;
      w_tx_done_nxt   = 1'b0;
      w_cmd_err_nxt   = 1'b0;
      w_pkt_count_nxt = r_pkt_count;
      w_buf_we        = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.cmd_valid) begin
               if (bus.cmd_len == LEN_W'(0) || bus.cmd_addr == 2'd3) begin
                  w_cmd_err_nxt = 1'b1;
               end else begin
                  w_len_nxt    = bus.cmd_len;
                  w_hdr_nxt    = {bus.cmd_len, bus.cmd_addr};
                  w_inj_nxt    = bus.cmd_inj_err;
                  w_parity_nxt = {bus.cmd_len, bus.cmd_addr};
                  w_wptr_nxt   = '0;
                  w_state_nxt  = FILL;
               end
            end
         end
         FILL: begin
            if (bus.src_valid) begin
               w_buf_we     = 1'b1;
               w_parity_nxt = r_parity ^ bus.src_data;
               w_wptr_nxt   = r_wptr + LEN_W'(1);
               if (r_wptr == w_last_idx) begin
                  w_state_nxt     = HEADER;
                  w_tx_data_nxt   = r_hdr;
                  w_pkt_valid_nxt = 1'b1;
               end
            end
         end
         HEADER: begin
            if (!bus.busy) begin
               w_state_nxt   = PAYLOAD;
               w_rptr_nxt    = '0;
               w_tx_data_nxt = r_buf[0];
            end
         end
         PAYLOAD: begin
            if (!bus.busy) begin
               if (r_rptr == w_last_idx) begin
                  w_state_nxt     = PARITY;
                  w_tx_data_nxt   = r_parity ^ {{(BYTE_W-1){1'b0}}, r_inj};
                  w_pkt_valid_nxt = 1'b0;
               end else begin
                  w_rptr_nxt    = w_rptr_inc;
                  w_tx_data_nxt = r_buf[w_rptr_inc];
               end
            end
         end
         PARITY: begin
            if (!bus.busy) begin
               w_tx_done_nxt   = 1'b1;
               w_pkt_count_nxt = r_pkt_count + CNT_W'(1);
               w_tx_data_nxt   = '0;
               w_gap_nxt       = '0;
               w_state_nxt     = GAP;
            end
         end
         GAP: begin
            if (r_gap == GAP_W'(IPG - 1)) w_state_nxt = IDLE;
            else                          w_gap_nxt   = r_gap + GAP_W'(1);
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Ready flags decode state only; cmd_ready is also held low during reset.
   assign bus.cmd_ready = (r_state == IDLE) && !reset;
   assign bus.src_ready = (r_state == FILL);
   assign bus.tx_data   = r_tx_data;
   assign bus.pkt_valid = r_pkt_valid;
   assign bus.tx_done   = r_tx_done;
   assign bus.cmd_err   = r_cmd_err;
   assign bus.pkt_count = r_pkt_count;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: cycle tables for the framing corners,
// plus a byte-stream reference model for long and randomized packets.
module tb_router_pkt_tx;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned IPG   = 2;

   logic clk;
   logic rst;

   router_pkt_tx_if #(.CNT_W(CNT_W)) bus ();

   router_pkt_tx #(.IPG(IPG), .CNT_W(CNT_W)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   typedef struct {
      logic       busy;
      logic [7:0] tx;
      logic       pv;
      logic       done;
      logic       rdy;
   } row_t;

   row_t       rows[$];
   int         checks    = 0;
   int         failures  = 0;
   int         exp_count = 0;
   int         obs_rd    = 0;
   logic       busy_row  = 1'b0;
   logic       rb_en     = 1'b0;
   logic       mon_en    = 1'b0;
   logic       in_frame  = 1'b0;
   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];
   logic [7:0] pl[64];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Sole driver of busy: either the current table row or random back-pressure.
   initial begin
      bus.busy = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bus.busy = rb_en ? ($urandom_range(0, 2) == 0) : busy_row;
      end
   end

   // Records every byte the router will consume at the coming edge as {pkt_valid, data}.
   always @(negedge clk) begin
      if (!mon_en) begin
         in_frame = 1'b0;
         obs_q.delete();
      end else if (rst) begin
         in_frame = 1'b0;
      end else if (!bus.busy && (bus.pkt_valid || in_frame)) begin
         obs_q.push_back({bus.pkt_valid, bus.tx_data});
         in_frame = bus.pkt_valid;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic b, input logic [7:0] t, input logic pv,
                               input logic d, input logic r);
      rows.push_back('{busy: b, tx: t, pv: pv, done: d, rdy: r});
   endfunction

   // Reference: header {len,addr}, payload in order, then XOR of all of them (bit 0 flipped on inject).
   task automatic expect_pkt(input logic [1:0] a, input logic [5:0] l, input logic inj);
      logic [7:0] p;
      p = {l, a};
      exp_q.push_back({1'b1, p});
      for (int i = 0; i < int'(l); i++) begin
         exp_q.push_back({1'b1, pl[i]});
         p = p ^ pl[i];
      end
      exp_q.push_back({1'b0, p ^ {7'b0, inj}});
   endtask

   // Offer a command, then stream pl[0..l-1]; returns aligned at posedge+1 after the last accept.
   task automatic load(input logic [1:0] a, input logic [5:0] l, input logic inj, input int gapmode);
      logic r;
      logic ok;
      int   idx;
      int   cyc;
      ok = 1'b0;
      bus.cmd_valid   = 1'b1;
      bus.cmd_addr    = a;
      bus.cmd_len     = l;
      bus.cmd_inj_err = inj;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         r = bus.cmd_ready;
         @(posedge clk);
         #1;
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      bus.cmd_valid = 1'b0;
      chk("cmd_accept_in_time", 32'(ok), 32'(1));
      idx = 0;
      cyc = 0;
      while (idx < int'(l) && cyc < 2000) begin
         if (gapmode == 0)      bus.src_valid = 1'b1;
         else if (gapmode == 1) bus.src_valid = (cyc % 2 == 0);
         else                   bus.src_valid = 1'($urandom_range(0, 1));
         bus.src_data = pl[idx];
         @(negedge clk);
         r = bus.src_ready;
         @(posedge clk);
         if (bus.src_valid && r) idx++;
         #1;
         cyc++;
      end
      bus.src_valid = 1'b0;
      chk("payload_accepted_in_time", 32'(idx), 32'(l));
   endtask

   task automatic run_rows(input int lo, input int hi, input string name);
      for (int i = lo; i < hi; i++) begin
         busy_row = rows[i].busy;
         @(negedge clk);
         chk($sformatf("%s_cyc%0d {tx,pv,done,cmd_ready}", name, i - lo),
             32'({bus.tx_data, bus.pkt_valid, bus.tx_done, bus.cmd_ready}),
             32'({rows[i].tx, rows[i].pv, rows[i].done, rows[i].rdy}));
         @(posedge clk);
         #1;
      end
      busy_row = 1'b0;
   endtask

   task automatic send(input logic [1:0] a, input logic [5:0] l, input logic inj,
                       input int gapmode, input string name);
      logic got;
      int   n;
      got = 1'b0;
      expect_pkt(a, l, inj);
      exp_count++;
      load(a, l, inj, gapmode);
      for (int k = 0; k < 3000 && !got; k++) begin
         @(negedge clk);
         got = bus.tx_done;
         @(posedge clk);
         #1;
      end
      chk({name, "_tx_done_seen"}, 32'(got), 32'(1));
      n = exp_q.size();
      chk({name, "_byte_count"}, 32'(obs_q.size() - obs_rd), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (obs_rd + i < obs_q.size())
            chk($sformatf("%s_byte%0d", name, i), 32'(obs_q[obs_rd + i]), 32'(exp_q[i]));
      end
      obs_rd = obs_q.size();
      exp_q.delete();
      chk({name, "_pkt_count"}, 32'(bus.pkt_count), 32'(exp_count));
   endtask

   task automatic set_test1_payload();
      pl[0] = 8'h11;
      pl[1] = 8'h22;
      pl[2] = 8'h33;
   endtask

   task automatic bad_cmd(input logic [1:0] a, input logic [5:0] l, input string name);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = a;
      bus.cmd_len   = l;
      @(negedge clk);
      chk({name, "_ready"}, 32'(bus.cmd_ready), 32'(1));
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk({name, "_err_pulse {err,pv,rdy}"}, 32'({bus.cmd_err, bus.pkt_valid, bus.cmd_ready}), 32'(3'b101));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({name, "_err_clears {err,pv,rdy}"}, 32'({bus.cmd_err, bus.pkt_valid, bus.cmd_ready}), 32'(3'b001));
      chk({name, "_pkt_count"}, 32'(bus.pkt_count), 32'(exp_count));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic found;
      rst             = 1'b1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_addr    = 2'd0;
      bus.cmd_len     = 6'd0;
      bus.cmd_inj_err = 1'b0;
      bus.src_data    = 8'h00;
      bus.src_valid   = 1'b0;

      // test 1 (busy low): header..payload, parity, done pulse, 2 gap cycles, ready
      add(0, 8'h0D, 1, 0, 0); add(0, 8'h11, 1, 0, 0); add(0, 8'h22, 1, 0, 0); add(0, 8'h33, 1, 0, 0);
      add(0, 8'h0D, 0, 0, 0); add(0, 8'h00, 0, 1, 0); add(0, 8'h00, 0, 0, 0); add(0, 8'h00, 0, 0, 1);
      // test 2: busy over 3 header cycles and once on 0x22
      add(1, 8'h0D, 1, 0, 0); add(1, 8'h0D, 1, 0, 0); add(1, 8'h0D, 1, 0, 0); add(0, 8'h0D, 1, 0, 0);
      add(0, 8'h11, 1, 0, 0); add(1, 8'h22, 1, 0, 0); add(0, 8'h22, 1, 0, 0); add(0, 8'h33, 1, 0, 0);
      add(0, 8'h0D, 0, 0, 0); add(0, 8'h00, 0, 1, 0); add(0, 8'h00, 0, 0, 0); add(0, 8'h00, 0, 0, 1);
      // test 4: injected parity error flips bit 0 of the parity byte only
      add(0, 8'h0D, 1, 0, 0); add(0, 8'h11, 1, 0, 0); add(0, 8'h22, 1, 0, 0); add(0, 8'h33, 1, 0, 0);
      add(0, 8'h0C, 0, 0, 0); add(0, 8'h00, 0, 1, 0); add(0, 8'h00, 0, 0, 0); add(0, 8'h00, 0, 0, 1);

      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset {tx,pv,done,err}", 32'({bus.tx_data, bus.pkt_valid, bus.tx_done, bus.cmd_err}), 32'(0));
      chk("reset pkt_count", 32'(bus.pkt_count), 32'(0));
      chk("reset {cmd_ready,src_ready}", 32'({bus.cmd_ready, bus.src_ready}), 32'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset cmd_ready", 32'(bus.cmd_ready), 32'(1));
      @(posedge clk);
      #1;

      set_test1_payload();
      load(2'd1, 6'd3, 1'b0, 0);
      run_rows(0, 8, "t1");
      exp_count++;
      chk("t1_pkt_count", 32'(bus.pkt_count), 32'(exp_count));

      load(2'd1, 6'd3, 1'b0, 0);
      run_rows(8, 20, "t2");
      exp_count++;
      chk("t2_pkt_count", 32'(bus.pkt_count), 32'(exp_count));

      bad_cmd(2'd1, 6'd0, "t3_len0");
      bad_cmd(2'd3, 6'd5, "t3_addr3");

      load(2'd1, 6'd3, 1'b1, 0);
      run_rows(20, 28, "t4");
      exp_count++;
      chk("t4_pkt_count", 32'(bus.pkt_count), 32'(exp_count));

      mon_en = 1'b1;
      obs_rd = 0;
      for (int i = 0; i < 63; i++) pl[i] = 8'(i);
      send(2'd2, 6'd63, 1'b0, 1, "t5_len63");

      rb_en = 1'b1;
      for (int p = 0; p < 25; p++) begin
         logic [1:0] a;
         logic [5:0] l;
         a = 2'($urandom_range(0, 2));
         l = 6'($urandom_range(1, 40));
         if (p == 0) l = 6'd1;
         for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
         send(a, l, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), $sformatf("rnd%0d", p));
      end
      rb_en = 1'b0;
      mon_en = 1'b0;
      @(posedge clk);
      #1;

      // test 6: reset lands while payload byte 5 is on the bus
      for (int i = 0; i < 10; i++) pl[i] = 8'hA0 + 8'(i);
      load(2'd0, 6'd10, 1'b0, 0);
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (bus.pkt_valid && bus.tx_data == 8'hA5) found = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("t6_reached_byte5", 32'(found), 32'(1));
      #1;
      rst = 1'b1;
      #1;
      chk("t6_async_clear {tx,pv}", 32'({bus.tx_data, bus.pkt_valid}), 32'(0));
      chk("t6_ready_in_reset", 32'(bus.cmd_ready), 32'(0));
      exp_count = 0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_release cmd_ready", 32'(bus.cmd_ready), 32'(1));
      chk("t6_release pkt_count", 32'(bus.pkt_count), 32'(0));
      @(posedge clk);
      #1;
      set_test1_payload();
      load(2'd1, 6'd3, 1'b0, 0);
      run_rows(0, 8, "t6_retx");
      exp_count++;
      chk("t6_pkt_count", 32'(bus.pkt_count), 32'(exp_count));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
